// File: rtl/icache_pkg.sv
// Shared parameters and types for the instruction cache.
// The cache statistics counters are built only when ICACHE_STATS_EN is defined.
package params_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;

    typedef enum logic {
        BYTE = 1'b0,
        WORD = 1'b1
    } access_size_t;

    localparam int ICACHE_NUM_LINES      = 4;
    localparam int ICACHE_WORDS_PER_LINE = 4;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        REFILL_REQ  = 3'd1,
        REFILL_WAIT = 3'd2,
        RESPOND     = 3'd3,
        BYPASS_WAIT = 3'd4
    } icache_state_t;

endpackage

// File: rtl/icache_if.sv
// CPU-side and memory-side request/response bundle of the instruction cache.
// The slave modport is the cache; the master modport is the CPU and memory around it.
interface icache_if;
    import params_pkg::*;

    logic                  cpu_rd_req_valid_i;
    logic                  cpu_wr_req_valid_i;
    logic                  cpu_req_is_instr_i;
    logic [ADDR_WIDTH-1:0] cpu_req_address_i;
    logic [DATA_WIDTH-1:0] cpu_wr_data_i;
    access_size_t          cpu_req_access_size_i;
    logic                  cpu_data_valid_o;
    logic                  cpu_data_is_instr_o;
    logic [DATA_WIDTH-1:0] cpu_data_o;

    logic                  mem_rd_req_valid_o;
    logic                  mem_wr_req_valid_o;
    logic                  mem_req_is_instr_o;
    logic [ADDR_WIDTH-1:0] mem_req_address_o;
    logic [DATA_WIDTH-1:0] mem_wr_data_o;
    access_size_t          mem_req_access_size_o;
    logic                  mem_data_valid_i;
    logic                  mem_data_is_instr_i;
    logic [DATA_WIDTH-1:0] mem_data_i;

    modport slave (
        input  cpu_rd_req_valid_i, cpu_wr_req_valid_i, cpu_req_is_instr_i,
               cpu_req_address_i, cpu_wr_data_i, cpu_req_access_size_i,
               mem_data_valid_i, mem_data_is_instr_i, mem_data_i,
        output cpu_data_valid_o, cpu_data_is_instr_o, cpu_data_o,
               mem_rd_req_valid_o, mem_wr_req_valid_o, mem_req_is_instr_o,
               mem_req_address_o, mem_wr_data_o, mem_req_access_size_o
    );

    modport master (
        output cpu_rd_req_valid_i, cpu_wr_req_valid_i, cpu_req_is_instr_i,
               cpu_req_address_i, cpu_wr_data_i, cpu_req_access_size_i,
               mem_data_valid_i, mem_data_is_instr_i, mem_data_i,
        input  cpu_data_valid_o, cpu_data_is_instr_o, cpu_data_o,
               mem_rd_req_valid_o, mem_wr_req_valid_o, mem_req_is_instr_o,
               mem_req_address_o, mem_wr_data_o, mem_req_access_size_o
    );

endinterface

// File: rtl/icache_array.sv
// Tag/valid/data storage: asynchronous read port, whole-line write port, invalidate port.
// Only the valid bits are reset; tags and data are qualified by them.
module icache_array
    import params_pkg::*;
#(
    parameter int NUM_LINES      = ICACHE_NUM_LINES,
    parameter int WORDS_PER_LINE = ICACHE_WORDS_PER_LINE,
    parameter int IDX_W          = $clog2(NUM_LINES),
    parameter int WORD_W         = $clog2(WORDS_PER_LINE),
    parameter int TAG_W          = ADDR_WIDTH - 2 - WORD_W - IDX_W
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,

    input  logic [IDX_W-1:0]                          rd_index,
    input  logic [WORD_W-1:0]                         rd_word,
    output logic                                      rd_valid,
    output logic [TAG_W-1:0]                          rd_tag,
    output logic [DATA_WIDTH-1:0]                     rd_data,

    input  logic                                      line_wr_en,
    input  logic [IDX_W-1:0]                          line_wr_index,
    input  logic [TAG_W-1:0]                          line_wr_tag,
    input  logic [WORDS_PER_LINE-1:0][DATA_WIDTH-1:0] line_wr_data,

    input  logic                                      inv_en,
    input  logic [IDX_W-1:0]                          inv_index
);

    logic [NUM_LINES-1:0]                      valid_q;
    logic [TAG_W-1:0]                          tag_q  [NUM_LINES];
    logic [WORDS_PER_LINE-1:0][DATA_WIDTH-1:0] data_q [NUM_LINES];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= '0;
        end else begin
            if (line_wr_en) valid_q[line_wr_index] <= 1'b1;
            if (inv_en)     valid_q[inv_index]     <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (line_wr_en) begin
            tag_q[line_wr_index]  <= line_wr_tag;
            data_q[line_wr_index] <= line_wr_data;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[rd_index][rd_word];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache with uncached pass-through for data requests.
// Define ICACHE_STATS_EN to add saturating hit/miss counters (stat_hits_o, stat_misses_o).
module icache
    import params_pkg::*;
#(
    parameter int NUM_LINES      = ICACHE_NUM_LINES,
    parameter int WORDS_PER_LINE = ICACHE_WORDS_PER_LINE
) (
    input  logic        clk_i,
    input  logic        rst_i,
    icache_if.slave     bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] stat_hits_o,
    output logic [31:0] stat_misses_o
`endif
);

    localparam int WORD_W  = $clog2(WORDS_PER_LINE);
    localparam int IDX_W   = $clog2(NUM_LINES);
    localparam int TAG_W   = ADDR_WIDTH - 2 - WORD_W - IDX_W;
    localparam int IDX_LSB = 2 + WORD_W;
    localparam int TAG_LSB = IDX_LSB + IDX_W;

    icache_state_t state_q;
    logic [WORD_W-1:0] cnt_q;

    logic [TAG_W-1:0]  cpu_tag;
    logic [IDX_W-1:0]  cpu_idx;
    logic [WORD_W-1:0] cpu_word;
    logic idle, accept_wr, accept_rd, accept_fetch, accept_byp, hit;

    logic [IDX_W-1:0]  arr_rd_index;
    logic [WORD_W-1:0] arr_rd_word;
    logic              arr_rd_valid;
    logic [TAG_W-1:0]  arr_rd_tag;
    logic [DATA_WIDTH-1:0] arr_rd_data;
    logic              line_wr_en;
    logic [WORDS_PER_LINE-1:0][DATA_WIDTH-1:0] line_wr_data;
    logic              inv_en;

    logic [TAG_W-1:0]  req_tag_p1;
    logic [IDX_W-1:0]  req_idx_p1;
    logic [WORD_W-1:0] req_word_p1;
    logic [WORDS_PER_LINE-1:0][DATA_WIDTH-1:0] line_buf_p1;

    logic                  hit_vld_p1;
    logic [DATA_WIDTH-1:0] hit_data_p1;

    logic                  byp_vld_p1;
    logic                  byp_wr_p1;
    logic                  byp_instr_p1;
    logic [ADDR_WIDTH-1:0] byp_addr_p1;
    logic [DATA_WIDTH-1:0] byp_wdata_p1;
    access_size_t          byp_size_p1;

    assign cpu_tag  = bus.cpu_req_address_i[ADDR_WIDTH-1:TAG_LSB];
    assign cpu_idx  = bus.cpu_req_address_i[TAG_LSB-1:IDX_LSB];
    assign cpu_word = bus.cpu_req_address_i[IDX_LSB-1:2];

    // Write wins when rd and wr arrive together; only IDLE accepts anything.
    assign idle         = (state_q == IDLE);
    assign accept_wr    = idle & bus.cpu_wr_req_valid_i;
    assign accept_rd    = idle & bus.cpu_rd_req_valid_i & ~bus.cpu_wr_req_valid_i;
    assign accept_fetch = accept_rd & bus.cpu_req_is_instr_i;
    assign accept_byp   = accept_wr | (accept_rd & ~bus.cpu_req_is_instr_i);

    assign arr_rd_index = idle ? cpu_idx  : req_idx_p1;
    assign arr_rd_word  = idle ? cpu_word : req_word_p1;
    assign hit          = arr_rd_valid & (arr_rd_tag == cpu_tag);

    assign inv_en     = accept_wr & hit;
    assign line_wr_en = (state_q == REFILL_WAIT) & bus.mem_data_valid_i & (&cnt_q);

    // The final refill word goes straight into the line alongside the buffered ones.
    always_comb begin
        line_wr_data        = line_buf_p1;
        line_wr_data[cnt_q] = bus.mem_data_i;
    end

    icache_array #(
        .NUM_LINES      (NUM_LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_array (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .rd_index      (arr_rd_index),
        .rd_word       (arr_rd_word),
        .rd_valid      (arr_rd_valid),
        .rd_tag        (arr_rd_tag),
        .rd_data       (arr_rd_data),
        .line_wr_en    (line_wr_en),
        .line_wr_index (req_idx_p1),
        .line_wr_tag   (req_tag_p1),
        .line_wr_data  (line_wr_data),
        .inv_en        (inv_en),
        .inv_index     (cpu_idx)
    );

    // Stage p0 -> p1: control state
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            hit_vld_p1 <= 1'b0;
            byp_vld_p1 <= 1'b0;
        end else begin
            hit_vld_p1 <= accept_fetch & hit;
            byp_vld_p1 <= accept_byp;
            unique case (state_q)
                IDLE: begin
                    if (accept_byp) begin
                        state_q <= BYPASS_WAIT;
                    end else if (accept_fetch && !hit) begin
                        state_q <= REFILL_REQ;
                        cnt_q   <= '0;
                    end
                end
                REFILL_REQ: state_q <= REFILL_WAIT;
                REFILL_WAIT: begin
                    if (bus.mem_data_valid_i) begin
                        if (&cnt_q) begin
                            state_q <= RESPOND;
                        end else begin
                            cnt_q   <= cnt_q + 1'b1;
                            state_q <= REFILL_REQ;
                        end
                    end
                end
                RESPOND:     state_q <= IDLE;
                BYPASS_WAIT: if (bus.mem_data_valid_i) state_q <= IDLE;
                default:     state_q <= IDLE;
            endcase
        end
    end

    // Stage p0 -> p1: datapath captures
    always_ff @(posedge clk_i) begin
        if (accept_fetch) begin
            req_tag_p1  <= cpu_tag;
            req_idx_p1  <= cpu_idx;
            req_word_p1 <= cpu_word;
        end
        if (accept_fetch && hit) hit_data_p1 <= arr_rd_data;
        if (accept_byp) begin
            byp_wr_p1    <= bus.cpu_wr_req_valid_i;
            byp_instr_p1 <= bus.cpu_req_is_instr_i;
            byp_addr_p1  <= bus.cpu_req_address_i;
            byp_wdata_p1 <= bus.cpu_wr_data_i;
            byp_size_p1  <= bus.cpu_req_access_size_i;
        end
        if (state_q == REFILL_WAIT && bus.mem_data_valid_i) line_buf_p1[cnt_q] <= bus.mem_data_i;
    end

    always_comb begin
        bus.mem_rd_req_valid_o    = 1'b0;
        bus.mem_wr_req_valid_o    = 1'b0;
        bus.mem_req_is_instr_o    = 1'b0;
        bus.mem_req_address_o     = '0;
        bus.mem_wr_data_o         = '0;
        bus.mem_req_access_size_o = BYTE;
        if (state_q == REFILL_REQ) begin
            bus.mem_rd_req_valid_o    = 1'b1;
            bus.mem_req_is_instr_o    = 1'b1;
            bus.mem_req_address_o     = {req_tag_p1, req_idx_p1, cnt_q, 2'b00};
            bus.mem_req_access_size_o = WORD;
        end else if (byp_vld_p1) begin
            bus.mem_rd_req_valid_o    = ~byp_wr_p1;
            bus.mem_wr_req_valid_o    = byp_wr_p1;
            bus.mem_req_is_instr_o    = byp_instr_p1;
            bus.mem_req_address_o     = byp_addr_p1;
            bus.mem_wr_data_o         = byp_wdata_p1;
            bus.mem_req_access_size_o = byp_size_p1;
        end
    end

    always_comb begin
        bus.cpu_data_valid_o    = 1'b0;
        bus.cpu_data_is_instr_o = 1'b0;
        bus.cpu_data_o          = '0;
        if (hit_vld_p1) begin
            bus.cpu_data_valid_o    = 1'b1;
            bus.cpu_data_is_instr_o = 1'b1;
            bus.cpu_data_o          = hit_data_p1;
        end else if (state_q == RESPOND) begin
            bus.cpu_data_valid_o    = 1'b1;
            bus.cpu_data_is_instr_o = 1'b1;
            bus.cpu_data_o          = arr_rd_data;
        end else if (state_q == BYPASS_WAIT && bus.mem_data_valid_i) begin
            bus.cpu_data_valid_o    = 1'b1;
            bus.cpu_data_is_instr_o = bus.mem_data_is_instr_i;
            bus.cpu_data_o          = bus.mem_data_i;
        end
    end

`ifdef ICACHE_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stat_hits_o   <= '0;
            stat_misses_o <= '0;
        end else if (accept_fetch) begin
            if (hit) stat_hits_o   <= sat_inc(stat_hits_o);
            else     stat_misses_o <= sat_inc(stat_misses_o);
        end
    end
`endif

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: a responder models memory; expected CPU responses and
// memory requests are queued as stimulus is issued and compared as the DUT produces them.
module tb_icache;
    import params_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    icache_if bus();

`ifdef ICACHE_STATS_EN
    logic [31:0] stat_hits, stat_misses;
`endif

    icache #(
        .NUM_LINES      (4),
        .WORDS_PER_LINE (4)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
`ifdef ICACHE_STATS_EN
        ,
        .stat_hits_o   (stat_hits),
        .stat_misses_o (stat_misses)
`endif
    );

    localparam logic [31:0] WR_ACK = 32'h00AC_CE55;

    typedef struct packed {
        logic [31:0]  addr;
        logic         rd;
        logic         wr;
        logic         instr;
        access_size_t size;
        logic [31:0]  wdata;
    } mreq_t;

    typedef struct packed {
        logic [31:0] data;
        logic        instr;
    } resp_t;

    mreq_t       mreq_q[$];
    resp_t       resp_q[$];
    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];
    logic        m_valid [4];
    logic [25:0] m_tag   [4];

    int n_checks = 0;
    int n_errors = 0;
    int mem_req_seen = 0;
    int exp_hits = 0;
    int exp_misses = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic check_stats(input string tag);
`ifdef ICACHE_STATS_EN
        check({tag, "_hits"},   stat_hits,   exp_hits);
        check({tag, "_misses"}, stat_misses, exp_misses);
`else
        if (tag.len() == 0) n_checks = n_checks + 0;
`endif
    endtask

    // Memory responder: answers each request two cycles after seeing it.
    initial begin : mem_model
        int          cnt;
        logic [31:0] a;
        logic        w;
        logic        ins;
        cnt = -1;
        a   = '0;
        w   = 1'b0;
        ins = 1'b0;
        bus.mem_data_valid_i    = 1'b0;
        bus.mem_data_is_instr_i = 1'b0;
        bus.mem_data_i          = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_data_valid_i    = 1'b0;
            bus.mem_data_is_instr_i = 1'b0;
            bus.mem_data_i          = '0;
            if (!rst) begin
                cnt = -1;
            end else begin
                if (cnt == 0) begin
                    bus.mem_data_valid_i    = 1'b1;
                    bus.mem_data_is_instr_i = ins;
                    bus.mem_data_i          = w ? WR_ACK : mem[a[9:2]];
                    cnt = -1;
                end else if (cnt > 0) begin
                    cnt--;
                end
                if (bus.mem_rd_req_valid_o || bus.mem_wr_req_valid_o) begin
                    a   = bus.mem_req_address_o;
                    w   = bus.mem_wr_req_valid_o;
                    ins = bus.mem_req_is_instr_o;
                    cnt = 1;
                    if (w) mem[a[9:2]] = bus.mem_wr_data_o;
                end
            end
        end
    end

    initial begin : resp_mon
        resp_t e;
        forever begin
            @(negedge clk);
            if (bus.cpu_data_valid_o === 1'b1) begin
                if (resp_q.size() == 0) begin
                    check("resp_unexpected", bus.cpu_data_valid_o, resp_q.size() != 0);
                end else begin
                    e = resp_q.pop_front();
                    check("resp_data",  bus.cpu_data_o,          e.data);
                    check("resp_instr", bus.cpu_data_is_instr_o, e.instr);
                end
            end
        end
    end

    initial begin : mreq_mon
        mreq_t e;
        forever begin
            @(negedge clk);
            if (bus.mem_rd_req_valid_o === 1'b1 || bus.mem_wr_req_valid_o === 1'b1) begin
                mem_req_seen++;
                if (mreq_q.size() == 0) begin
                    check("mem_req_unexpected", 1'b1, mreq_q.size() != 0);
                end else begin
                    e = mreq_q.pop_front();
                    check("mem_addr", bus.mem_req_address_o, e.addr);
                    check("mem_kind",
                          {bus.mem_rd_req_valid_o, bus.mem_wr_req_valid_o,
                           bus.mem_req_is_instr_o, bus.mem_req_access_size_o},
                          {e.rd, e.wr, e.instr, e.size});
                    check("mem_wdata", bus.mem_wr_data_o, e.wdata);
                end
            end
        end
    end

    task automatic idle_inputs();
        bus.cpu_rd_req_valid_i    = 1'b0;
        bus.cpu_wr_req_valid_i    = 1'b0;
        bus.cpu_req_is_instr_i    = 1'b0;
        bus.cpu_req_address_i     = '0;
        bus.cpu_wr_data_i         = '0;
        bus.cpu_req_access_size_i = WORD;
    endtask

    task automatic wait_drain(input string tag);
        int c;
        c = 0;
        while ((resp_q.size() != 0 || mreq_q.size() != 0) && c < 200) begin
            @(negedge clk);
            c++;
        end
        check({tag, "_resp_drain"}, resp_q.size(), 0);
        check({tag, "_mreq_drain"}, mreq_q.size(), 0);
        resp_q.delete();
        mreq_q.delete();
    endtask

    task automatic push_refill(input logic [31:0] a);
        mreq_t m;
        for (int k = 0; k < 4; k++) begin
            m.addr  = {a[31:4], 4'(k * 4)};
            m.rd    = 1'b1;
            m.wr    = 1'b0;
            m.instr = 1'b1;
            m.size  = WORD;
            m.wdata = '0;
            mreq_q.push_back(m);
        end
    endtask

    task automatic cpu_fetch(input logic [31:0] a, input access_size_t sz);
        logic [1:0]  idx;
        logic [25:0] tg;
        logic        hit;
        resp_t       r;
        idx = a[5:4];
        tg  = a[31:6];
        hit = m_valid[idx] && (m_tag[idx] == tg);
        if (hit) begin
            exp_hits++;
        end else begin
            exp_misses++;
            push_refill(a);
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
        end
        r.data  = ref_mem[a[9:2]];
        r.instr = 1'b1;
        resp_q.push_back(r);
        @(posedge clk);
        #1;
        bus.cpu_rd_req_valid_i    = 1'b1;
        bus.cpu_req_is_instr_i    = 1'b1;
        bus.cpu_req_address_i     = a;
        bus.cpu_req_access_size_i = sz;
        @(posedge clk);
        #1;
        idle_inputs();
        if (hit) begin
            @(negedge clk);
            check("hit_latency", bus.cpu_data_valid_o, 1'b1);
        end
        wait_drain("fetch");
    endtask

    task automatic cpu_data(input logic rd, input logic wr, input logic [31:0] a,
                            input access_size_t sz, input logic [31:0] wd);
        logic [1:0]  idx;
        logic [25:0] tg;
        mreq_t       m;
        resp_t       r;
        idx     = a[5:4];
        tg      = a[31:6];
        m.addr  = a;
        m.rd    = rd & ~wr;
        m.wr    = wr;
        m.instr = 1'b0;
        m.size  = sz;
        m.wdata = wd;
        mreq_q.push_back(m);
        if (wr) begin
            r.data = WR_ACK;
            if (m_valid[idx] && m_tag[idx] == tg) m_valid[idx] = 1'b0;
            if (sz == WORD) ref_mem[a[9:2]] = wd;
        end else begin
            r.data = ref_mem[a[9:2]];
        end
        r.instr = 1'b0;
        resp_q.push_back(r);
        @(posedge clk);
        #1;
        bus.cpu_rd_req_valid_i    = rd;
        bus.cpu_wr_req_valid_i    = wr;
        bus.cpu_req_is_instr_i    = 1'b0;
        bus.cpu_req_address_i     = a;
        bus.cpu_req_access_size_i = sz;
        bus.cpu_wr_data_i         = wd;
        @(posedge clk);
        #1;
        idle_inputs();
        wait_drain("data");
    endtask

    task automatic reset_mid_refill(input logic [31:0] a);
        int base;
        int c;
        push_refill(a);
        base = mem_req_seen;
        @(posedge clk);
        #1;
        bus.cpu_rd_req_valid_i = 1'b1;
        bus.cpu_req_is_instr_i = 1'b1;
        bus.cpu_req_address_i  = a;
        @(posedge clk);
        #1;
        idle_inputs();
        c = 0;
        while (mem_req_seen < base + 3 && c < 100) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("rst_refill_progress", mem_req_seen - base, 3);
        rst = 1'b0;
        #1;
        check("rst_mid_cpu_valid", bus.cpu_data_valid_o,   1'b0);
        check("rst_mid_cpu_data",  bus.cpu_data_o,         32'h0);
        check("rst_mid_mem_rd",    bus.mem_rd_req_valid_o, 1'b0);
        check("rst_mid_mem_wr",    bus.mem_wr_req_valid_o, 1'b0);
        check("rst_mid_mem_addr",  bus.mem_req_address_o,  32'h0);
        mreq_q.delete();
        resp_q.delete();
        for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
        exp_hits   = 0;
        exp_misses = 0;
        repeat (3) @(posedge clk);
        check_stats("rst_mid");
        @(negedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 32'hC0DE_0000 + 32'(i * 17);
            ref_mem[i] = 32'hC0DE_0000 + 32'(i * 17);
        end
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
        end
        idle_inputs();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cpu_valid",  bus.cpu_data_valid_o,    1'b0);
        check("rst_cpu_instr",  bus.cpu_data_is_instr_o, 1'b0);
        check("rst_cpu_data",   bus.cpu_data_o,          32'h0);
        check("rst_mem_rd",     bus.mem_rd_req_valid_o,  1'b0);
        check("rst_mem_wr",     bus.mem_wr_req_valid_o,  1'b0);
        check("rst_mem_addr",   bus.mem_req_address_o,   32'h0);
        check_stats("rst");
        @(negedge clk);
        rst = 1'b1;

        cpu_fetch(32'h0000_0000, WORD);
        check_stats("cold");
        cpu_fetch(32'h0000_0008, WORD);
        check_stats("hit");
        cpu_fetch(32'h0000_0004, BYTE);
        cpu_data(1'b0, 1'b1, 32'h0000_0004, WORD, 32'h1234_5678);
        cpu_fetch(32'h0000_0004, WORD);
        cpu_data(1'b1, 1'b0, 32'h0000_0022, BYTE, 32'h0);
        cpu_fetch(32'h0000_0040, WORD);
        cpu_fetch(32'h0000_0000, WORD);
        cpu_data(1'b1, 1'b1, 32'h0000_0030, WORD, 32'hDEAD_BEEF);
        cpu_data(1'b0, 1'b1, 32'h0000_0044, WORD, 32'h5555_AAAA);
        cpu_fetch(32'h0000_000C, WORD);
        check_stats("mixed");

        reset_mid_refill(32'h0000_0100);
        cpu_fetch(32'h0000_0100, WORD);
        cpu_fetch(32'h0000_0104, WORD);
        check_stats("after_rst");

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
